alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external combinational ALU. It queues commands, issues them one
// at a time, and returns the captured results and flags over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_tag,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic [3:0] rsp_tag,
  output logic [7:0] op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             rsp_done;
  logic [3:0]       tag_q;

  // Ready depends only on registered occupancy, so it never combinationally follows a pop.
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = mem[rd_ptr];
  assign rsp_valid = (state_q == RESP);

  // NOTE: the storage array has no reset; occupancy and pointers define which entries are
  // meaningful, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are loaded only on the edge that enters ISSUE and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      tag_q  <= '0;
    end else if (pop) begin
      alu_a  <= head.a;
      alu_b  <= head.b;
      alu_op <= head.op;
      tag_q  <= head.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_carry  <= alu_carry;
      rsp_tag    <= tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_done) begin
      op_count <= op_count + 8'd1;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: table-driven ALU vectors, hand-written multi-cycle sequences, and a
// randomized run scored against a queue-based reference model.
module tb_alu_op_sequencer;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] tag;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] cmd_tag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;
  logic [3:0] rsp_tag;
  logic [7:0] op_count;

  int   checks;
  int   failures;
  int   exp_count;
  int   n_pushed;
  int   push_limit;
  int   max_out;
  int   alt_err;
  int   alu_err;
  int   stab_err;
  int   pulses;
  cmd_t sb[$];
  vec_t vecs[12];

  alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_tag   (rsp_tag),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, zero, result}; subtraction reports a borrow as carry.
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [8:0] w;
    case (op)
      3'd0:    w = {1'b0, a};
      3'd1:    w = {1'b0, b};
      3'd2:    w = {1'b0, a} + {1'b0, b};
      3'd3:    w = {1'b0, a} - {1'b0, b};
      3'd4:    w = {1'b0, a & b};
      3'd5:    w = {1'b0, a | b};
      3'd6:    w = {1'b0, a ^ b};
      default: w = {1'b0, ~a};
    endcase
    return {w[8], (w[7:0] == 8'h00), w[7:0]};
  endfunction

  // External combinational ALU driven by the sequencer's registered operands.
  always_comb {alu_carry, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    sb.delete();
    exp_count = 0;
    n_pushed  = 0;
    @(negedge clk);
  endtask

  // One iteration per cycle, entered and left on a falling edge.
  task automatic run_cycles(input int n, input int p_valid, input int p_ready, input bit track);
    cmd_t        c;
    logic [9:0]  e;
    logic [13:0] held;
    logic [18:0] prev_alu;
    logic        prev_valid;
    logic        prev_stall;
    logic        started;
    prev_alu   = {alu_a, alu_b, alu_op};
    prev_valid = rsp_valid;
    prev_stall = 1'b0;
    started    = 1'b0;
    held       = '0;
    for (int i = 0; i < n; i++) begin
      check("op_count", op_count, exp_count[7:0]);
      if (prev_stall && !(rsp_valid && ({rsp_tag, rsp_carry, rsp_zero, rsp_result} == held)))
        stab_err++;
      if (({alu_a, alu_b, alu_op} != prev_alu) && rsp_valid) alu_err++;
      if (track) begin
        if (started && (rsp_valid == prev_valid)) alt_err++;
        if (rsp_valid) begin
          started = 1'b1;
          pulses++;
        end
      end
      prev_alu   = {alu_a, alu_b, alu_op};
      prev_valid = rsp_valid;

      rsp_ready = (int'($urandom_range(99)) < p_ready);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          c = sb.pop_front();
          e = alu_ref(c.a, c.b, c.op);
          check("rsp_data", {rsp_tag, rsp_carry, rsp_zero, rsp_result}, {c.tag, e});
          exp_count++;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      held       = {rsp_tag, rsp_carry, rsp_zero, rsp_result};

      cmd_valid = (n_pushed < push_limit) && (int'($urandom_range(99)) < p_valid);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_op    = 3'($urandom);
      cmd_tag   = 4'($urandom);
      if (cmd_valid && cmd_ready) begin
        sb.push_back(cmd_t'{cmd_a, cmd_b, cmd_op, cmd_tag});
        n_pushed++;
      end
      if (sb.size() > max_out) max_out = sb.size();
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          acc;
    int          got;
    int          seen;
    logic [13:0] snap;

    checks = 0; failures = 0; exp_count = 0; n_pushed = 0; push_limit = 1 << 30;
    max_out = 0; alt_err = 0; alu_err = 0; stab_err = 0; pulses = 0;
    rst_n = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;

    vecs[0]  = '{8'hFF, 8'h01, 3'b010, 4'd3,  8'h00, 1'b1, 1'b1};
    vecs[1]  = '{8'h05, 8'h07, 3'b011, 4'd5,  8'hFE, 1'b0, 1'b1};
    vecs[2]  = '{8'h0F, 8'h00, 3'b111, 4'd6,  8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{8'hA5, 8'h3C, 3'b000, 4'd1,  8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{8'hA5, 8'h3C, 3'b001, 4'd2,  8'h3C, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'h0F, 3'b100, 4'd7,  8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'hF0, 8'h0F, 3'b101, 4'd8,  8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{8'hAA, 8'hAA, 3'b110, 4'd9,  8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'h10, 8'h20, 3'b010, 4'd10, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{8'h20, 8'h20, 3'b011, 4'd11, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'h01, 3'b011, 4'd12, 8'hFF, 1'b0, 1'b1};
    vecs[11] = '{8'hFF, 8'h00, 3'b111, 4'd15, 8'h00, 1'b1, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_tag, rsp_carry, rsp_zero, rsp_result}, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors, each pushed into an idle sequencer with rsp_ready held high
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("v%0d_ready", i), cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_op = vecs[i].op; cmd_tag = vecs[i].tag;
      @(negedge clk);
      cmd_valid = 1'b0;
      check($sformatf("v%0d_lat1", i), rsp_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_lat2", i), rsp_valid, 0);
      check($sformatf("v%0d_alu", i), {alu_a, alu_b, alu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
      @(negedge clk);
      check($sformatf("v%0d_valid", i), rsp_valid, 1);
      check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {rsp_zero, rsp_carry}, {vecs[i].z, vecs[i].c});
      check($sformatf("v%0d_tag", i), rsp_tag, vecs[i].tag);
      @(negedge clk);
      exp_count++;
      check($sformatf("v%0d_op_count", i), op_count, exp_count[7:0]);
      check($sformatf("v%0d_done", i), rsp_valid, 0);
      check($sformatf("v%0d_alu_hold", i), {alu_a, alu_b, alu_op},
            {vecs[i].a, vecs[i].b, vecs[i].op});
    end

    // Back-pressure: six back-to-back offers, FIFO plus one in flight can take five
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 8'(i * 16); cmd_b = 8'h01; cmd_op = 3'b010; cmd_tag = 4'(i);
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_head", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd0, 8'h01});
    snap = {rsp_tag, rsp_carry, rsp_zero, rsp_result};
    repeat (3) @(negedge clk);
    check("bp_stable", {rsp_valid, rsp_tag, rsp_carry, rsp_zero, rsp_result}, {1'b1, snap});
    rsp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && got < 5; n++) begin
      if (rsp_valid) begin
        check("bp_order", {rsp_tag, rsp_result}, {4'(got), 8'(got * 16 + 1)});
        got++;
        exp_count++;
      end
      @(negedge clk);
    end
    check("bp_drained", got, 5);
    check("bp_cmd_ready_back", cmd_ready, 1);
    check("bp_op_count", op_count, exp_count[7:0]);

    // Reset while a response is pending and three commands are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 8'(i + 1); cmd_b = 8'h00; cmd_op = 3'b000; cmd_tag = 4'(i + 8);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("mid_pre_valid", rsp_valid, 1);
    check("mid_pre_full", cmd_ready, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_op_count", op_count, 0);
    check("mid_rsp", {rsp_tag, rsp_result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    sb.delete(); exp_count = 0; n_pushed = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_stale", seen, 0);
    check("mid_op_count_after", op_count, 0);

    // Continuous stream with rsp_ready held: one response every other cycle
    do_reset();
    max_out = 0;
    run_cycles(60, 100, 100, 1'b1);
    check("tp_pulses", pulses, 29);
    check("tp_alternate", alt_err, 0);
    check("tp_max_outstanding", max_out, FIFO_DEPTH + 1);
    run_cycles(20, 0, 100, 1'b0);
    check("tp_drain_empty", sb.size(), 0);

    // Randomized traffic with random back-pressure
    max_out = 0;
    run_cycles(600, 60, 50, 1'b0);
    run_cycles(40, 0, 100, 1'b0);
    check("rnd_drain_empty", sb.size(), 0);
    check("rnd_max_outstanding", max_out, FIFO_DEPTH + 1);

    // Exactly 256 responses wrap the counter back to zero
    do_reset();
    push_limit = 256;
    run_cycles(700, 100, 100, 1'b0);
    check("wrap_total", exp_count, 256);
    check("wrap_op_count", op_count, 8'h00);
    check("wrap_drain_empty", sb.size(), 0);

    check("alu_hold_outside_issue", alu_err, 0);
    check("rsp_stable_under_stall", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
